// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types for the pipeline bus masters.
// Request/response bundles plus arbiter state encoding.
package dbus_arbiter_pkg;

   localparam int NUM_DBUS_REQ = 2;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dbus_arbiter_picker.sv
// Round-robin priority picker: first eligible index
// at or above rr_ptr, wrapping around.
module rr_priority_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   sel,
   output logic               any_valid
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     off;
   logic [IDX_W:0]       sum;
   logic                 found;

   // Rotate so rr_ptr sits at bit 0, encode, then rotate the index back.
   always_comb begin
      dbl   = {eligible, eligible} >> rr_ptr;
      rot   = dbl[NUM_REQ-1:0];
      off   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            off   = IDX_W'(i);
            found = 1'b1;
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
         sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      sel       = sum[IDX_W-1:0];
      any_valid = |eligible;
   end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin data-bus arbiter: one transaction at a time,
// request latched for its duration, response routed to owner.
module dbus_arbiter
   import dbus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_DBUS_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic         clk,
   input  logic         rst,
   input  dbus_req_t    req   [NUM_REQ],
   output dbus_resp_t   resp  [NUM_REQ],
   output dbus_req_t    mreq,
   input  dbus_resp_t   mresp,
   output logic [NUM_REQ-1:0] grant,
   output logic         busy
);

   arb_state_t         state_q, state_d;
   dbus_req_t          mreq_q, mreq_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] holdoff_q, holdoff_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] eligible;
   logic [IDX_W-1:0]   pick_sel;
   logic               pick_any;
   logic               done;

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   // Gather valids; the last-served requester sits out one idle cycle.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = req[i].valid;
      end
      eligible = req_valid & ~holdoff_q;
   end

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_q),
      .sel       (pick_sel),
      .any_valid (pick_any)
   );

   assign done = mresp.addr_ok & mresp.data_ok;

   // Next-state: grant from idle, release on full handshake.
   always_comb begin
      state_d   = state_q;
      mreq_d    = mreq_q;
      sel_d     = sel_q;
      rr_ptr_d  = rr_ptr_q;
      holdoff_d = holdoff_q;
      grant_d   = grant_q;
      unique case (state_q)
         ARB_IDLE: begin
            holdoff_d = '0;
            if (pick_any) begin
               mreq_d       = req[pick_sel];
               mreq_d.valid = 1'b1;
               sel_d        = pick_sel;
               grant_d      = ONE << pick_sel;
               state_d      = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (done) begin
               mreq_d    = '0;
               grant_d   = '0;
               holdoff_d = ONE << sel_q;
               state_d   = ARB_IDLE;
               if (sel_q == IDX_W'(NUM_REQ-1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = sel_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and latched-request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         mreq_q    <= '0;
         sel_q     <= '0;
         rr_ptr_q  <= '0;
         holdoff_q <= '0;
         grant_q   <= '0;
      end else begin
         state_q   <= state_d;
         mreq_q    <= mreq_d;
         sel_q     <= sel_d;
         rr_ptr_q  <= rr_ptr_d;
         holdoff_q <= holdoff_d;
         grant_q   <= grant_d;
      end
   end

   // Response goes only to the current owner.
   always_comb begin
      for (int j = 0; j < NUM_REQ; j++) begin
         resp[j] = '0;
         if (!rst && state_q == ARB_BUSY && sel_q == IDX_W'(j)) begin
            resp[j] = mresp;
         end
      end
   end

   assign mreq  = mreq_q;
   assign grant = grant_q;
   assign busy  = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter.
// Two requesters, hand-computed expectations.
module tb_dbus_arbiter;
   import dbus_arbiter_pkg::*;

   logic       clk;
   logic       rst;
   dbus_req_t  req  [2];
   dbus_resp_t resp [2];
   dbus_req_t  mreq;
   dbus_resp_t mresp;
   logic [1:0] grant;
   logic       busy;

   int total;
   int bad;

   dbus_arbiter #(.NUM_REQ(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .resp  (resp),
      .mreq  (mreq),
      .mresp (mresp),
      .grant (grant),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ok(input logic [31:0] d);
      mresp.addr_ok = 1'b1;
      mresp.data_ok = 1'b1;
      mresp.data    = d;
   endtask

   initial begin
      logic [1:0]  exp_g;
      logic [31:0] exp_a;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req[0] = '0;
      req[1] = '0;
      mresp  = '0;
      tick();
      tick();
      chk("rst_valid", 64'(mreq.valid), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp0", 64'(resp[0]), 64'd0);
      rst = 1'b0;

      // single requester read
      req[0].valid  = 1'b1;
      req[0].addr   = 32'h8000_0010;
      req[0].strobe = 4'h0;
      tick();
      chk("rd_valid", 64'(mreq.valid), 64'd1);
      chk("rd_addr", 64'(mreq.addr), 64'h8000_0010);
      chk("rd_grant", 64'(grant), 64'b01);
      chk("rd_busy", 64'(busy), 64'd1);
      tick();
      ok(32'hDEAD_BEEF);
      #1;
      chk("rd_r0_ok", 64'(resp[0].data_ok), 64'd1);
      chk("rd_r0_data", 64'(resp[0].data), 64'hDEAD_BEEF);
      chk("rd_r1_zero", 64'(resp[1]), 64'd0);
      tick();
      mresp = '0;
      chk("rd_done_busy", 64'(busy), 64'd0);
      chk("rd_done_grant", 64'(grant), 64'd0);
      tick();
      chk("rd_holdoff", 64'(mreq.valid), 64'd0);
      req[0] = '0;

      // contention, from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req[0].valid = 1'b1;
      req[0].addr  = 32'h0000_1000;
      req[1].valid = 1'b1;
      req[1].addr  = 32'h0000_2000;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (k % 2 == 0) ? 32'h1000 : 32'h2000;
         tick();
         chk($sformatf("ct_grant%0d", k), 64'(grant), 64'(exp_g));
         chk($sformatf("ct_addr%0d", k), 64'(mreq.addr), 64'(exp_a));
         tick();
         ok(32'h100 + 32'(k));
         #1;
         chk($sformatf("ct_rsel%0d", k),
             64'({resp[1].data_ok, resp[0].data_ok}), 64'(exp_g));
         tick();
         mresp = '0;
         chk($sformatf("ct_idle%0d", k), 64'({busy, grant}), 64'd0);
      end
      req[0] = '0;
      req[1] = '0;
      tick();

      // field stability and partial handshake
      req[0].valid = 1'b1;
      req[0].addr  = 32'h100;
      tick();
      chk("fs_grant", 64'(grant), 64'b01);
      chk("fs_addr0", 64'(mreq.addr), 64'h100);
      req[0].addr = 32'h200;
      mresp.addr_ok = 1'b1;
      mresp.data_ok = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("ph_busy%0d", k), 64'(busy), 64'd1);
         chk($sformatf("fs_addr%0d", k + 1), 64'(mreq.addr), 64'h100);
      end
      ok(32'h55);
      tick();
      mresp = '0;
      chk("ph_done", 64'({busy, mreq.valid}), 64'd0);
      req[0] = '0;
      tick();

      // holdoff with a lone requester
      req[1].valid = 1'b1;
      req[1].addr  = 32'h300;
      tick();
      chk("ho_grant", 64'(grant), 64'b10);
      tick();
      ok(32'h77);
      tick();
      mresp = '0;
      chk("ho_done", 64'(busy), 64'd0);
      tick();
      chk("ho_nodup_v", 64'(mreq.valid), 64'd0);
      chk("ho_nodup_g", 64'(grant), 64'd0);
      req[1] = '0;
      tick();
      chk("ho_quiet", 64'(busy), 64'd0);

      // reset mid-transaction
      req[0].valid = 1'b1;
      req[0].addr  = 32'h400;
      tick();
      chk("rm_grant", 64'(grant), 64'b01);
      req[0] = '0;
      rst = 1'b1;
      ok(32'h99);
      tick();
      chk("rm_state", 64'({mreq.valid, grant, busy}), 64'd0);
      chk("rm_resp0", 64'(resp[0]), 64'd0);
      rst = 1'b0;
      mresp = '0;

      // post-reset req[1], dropping valid mid-transaction
      req[1].valid = 1'b1;
      req[1].addr  = 32'h500;
      tick();
      chk("pr_grant", 64'(grant), 64'b10);
      chk("pr_addr", 64'(mreq.addr), 64'h500);
      req[1] = '0;
      tick();
      ok(32'hCAFE_0001);
      #1;
      chk("pr_r1_ok", 64'(resp[1].data_ok), 64'd1);
      chk("pr_r1_data", 64'(resp[1].data), 64'hCAFE_0001);
      chk("pr_r0_zero", 64'(resp[0]), 64'd0);
      tick();
      mresp = '0;
      chk("pr_done", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
